// File: rtl/alu_pkg.sv
// alu_pkg: ALU_OP codes shared with the decoder and the execution-unit state encoding
package alu_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BLTU = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op == OP_SLL || op == OP_SRL || op == OP_SRA;
    endfunction
endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative one-bit-per-cycle shifter (load, step, last-step flag)
//   i_load : capture i_a, i_amt and shift kind from i_op
//   o_next : register value after one more step
//   o_last : the step producing o_next is the final one
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [SHAMT_W-1:0] i_amt,
    output logic [WIDTH-1:0]   o_next,
    output logic               o_last
);
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;

    assign o_next = r_left ? {r_data[WIDTH-2:0], 1'b0}
                           : {r_arith & r_data[WIDTH-1], r_data[WIDTH-1:1]};
    assign o_last = r_cnt == SHAMT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_a;
            r_cnt   <= i_amt;
            r_left  <= i_op == OP_SLL;
            r_arith <= i_op == OP_SRA;
        end else if (r_cnt != '0) begin
            r_data <= o_next;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle integer execution unit with valid/ready handshake
//   IN_VALID_i/IN_READY_o   : op + operands handshake (accepted only in IDLE)
//   ALU_OP_i, A_i, B_i      : operation code and operands
//   OUT_VALID_o/OUT_READY_i : result handshake, held in DONE until taken
//   RESULT_o, ZERO_o        : registered result; ZERO_o=1 means branch taken
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN_VALID_i,
    output logic             IN_READY_o,
    input  logic [3:0]       ALU_OP_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             OUT_VALID_o,
    input  logic             OUT_READY_i,
    output logic [WIDTH-1:0] RESULT_o,
    output logic             ZERO_o
);
    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               w_accept;
    logic               w_shift;
    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_last;
    logic               w_lt_s;
    logic               w_lt_u;

    assign IN_READY_o  = r_state == ST_IDLE;
    assign OUT_VALID_o = r_out_valid;
    assign RESULT_o    = r_result;
    assign ZERO_o      = r_zero;
    assign w_accept    = IN_VALID_i & IN_READY_o;
    assign w_shift     = is_shift(ALU_OP_i);
    assign w_amt       = B_i[SHAMT_W-1:0];
    assign w_lt_s      = $signed(A_i) < $signed(B_i);
    assign w_lt_u      = A_i < B_i;
    // A zero-amount shift finishes at accept with the operand unchanged
    assign w_res       = w_shift ? A_i : w_alu;

    always_comb begin
        w_alu = '0;
        case (ALU_OP_i)
            OP_AND:  w_alu = A_i & B_i;
            OP_OR:   w_alu = A_i | B_i;
            OP_XOR:  w_alu = A_i ^ B_i;
            OP_ADD:  w_alu = A_i + B_i;
            OP_SUB:  w_alu = A_i - B_i;
            OP_BNE:  w_alu = WIDTH'(A_i == B_i);
            OP_BLT:  w_alu = WIDTH'(!w_lt_s);
            OP_BLTU: w_alu = WIDTH'(!w_lt_u);
            OP_SLT:  w_alu = WIDTH'(w_lt_s);
            OP_SLTU: w_alu = WIDTH'(w_lt_u);
            default: w_alu = '0;
        endcase
    end

    alu_shift_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept & w_shift),
        .i_op   (ALU_OP_i),
        .i_a    (A_i),
        .i_amt  (w_amt),
        .o_next (w_sh_next),
        .o_last (w_sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    if (w_shift && w_amt != '0) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_result    <= w_res;
                        r_zero      <= w_res == '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                // Latch the final step directly so latency is amount+1
                ST_SHIFT: if (w_sh_last) begin
                    r_result    <= w_sh_next;
                    r_zero      <= w_sh_next == '0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: if (OUT_READY_i) begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
